// File: rtl/baseball_game_param.sv
// Number-baseball game engine. The player (or the internal LFSR in solo
// mode) sets a secret of NUM_DIGITS distinct digits. Guesses are scored as
// strikes and balls, and the game ends in a win or after MAX_ATTEMPTS guesses.
module baseball_game_param #(
    parameter int NUM_DIGITS   = 4,
    parameter int MAX_ATTEMPTS = 16,
    parameter int BLINK_DIV    = 50_000_000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    active,
    input  logic                    solo,
    input  logic                    btn_up,
    input  logic                    btn_down,
    input  logic                    btn_left,
    input  logic                    btn_right,
    input  logic                    btn_confirm,
    output logic [MAX_ATTEMPTS-1:0] led,
    output logic [5*NUM_DIGITS-1:0] seg_data,
    output logic                    win,
    output logic                    lose
);

    localparam int CW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int SW = $clog2(NUM_DIGITS + 1);
    localparam int AW = $clog2(MAX_ATTEMPTS + 1);
    localparam int LW = (MAX_ATTEMPTS > 1) ? $clog2(MAX_ATTEMPTS) : 1;
    localparam int BW = $clog2(BLINK_DIV);

    localparam logic [4:0] CH_DASH  = 5'd10;
    localparam logic [4:0] CH_E     = 5'd11;
    localparam logic [4:0] CH_R     = 5'd12;
    localparam logic [4:0] CH_S     = 5'd5;
    localparam logic [4:0] CH_B     = 5'd18;
    localparam logic [4:0] CH_O     = 5'd17;
    localparam logic [4:0] CH_G     = 5'd9;
    localparam logic [4:0] CH_D     = 5'd19;
    localparam logic [4:0] CH_L     = 5'd1;
    localparam logic [4:0] CH_BLANK = 5'd31;

    typedef enum logic [3:0] {
        S_IDLE, S_GEN_ANSWER, S_INPUT_ANSWER, S_ANSWER_CONFIRM, S_INPUT_GUESS,
        S_GUESS_ERR, S_SHOW_RESULT, S_GAME_WIN, S_GAME_LOSE
    } state_t;

    typedef logic [NUM_DIGITS-1:0][3:0] digits_t;
    typedef logic [NUM_DIGITS-1:0][4:0] chars_t;

    function automatic logic has_dup(input digits_t v);
        logic dup;
        dup = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++)
            for (int j = i + 1; j < NUM_DIGITS; j++)
                if (v[i] == v[j]) dup = 1'b1;
        return dup;
    endfunction

    // Four-character message in the leftmost slots, remaining slots blank.
    function automatic chars_t text4(input logic [4:0] c3, input logic [4:0] c2,
                                     input logic [4:0] c1, input logic [4:0] c0);
        chars_t t;
        t = '1;
        t[NUM_DIGITS-1] = c3;
        t[NUM_DIGITS-2] = c2;
        t[NUM_DIGITS-3] = c1;
        t[NUM_DIGITS-4] = c0;
        return t;
    endfunction

    state_t            state_q, state_d;
    digits_t           answer_q, answer_d, guess_q, guess_d;
    logic [CW-1:0]     cursor_q, cursor_d;
    logic [MAX_ATTEMPTS-1:0] led_q, led_d;
    logic [AW-1:0]     attempts_q, attempts_d;
    logic [SW-1:0]     strikes_q, strikes_d, balls_q, balls_d;
    logic [SW-1:0]     gen_idx_q, gen_idx_d;
    logic [4:0]        btn_prev_q;
    logic [15:0]       lfsr_q;
    logic [BW-1:0]     blink_cnt_q;
    logic              blink_q;

    logic [4:0]        btn_now, btn_edge;
    logic              e_up, e_down, e_left, e_right, e_confirm;
    logic              lfsr_fb, gen_used, gen_accept;
    logic [SW-1:0]     strikes_c, balls_c;
    digits_t           edit_src, edit_res;
    logic [3:0]        cur_digit;
    logic [CW-1:0]     cursor_mv;
    chars_t            seg_c;

    assign btn_now  = {btn_up, btn_down, btn_left, btn_right, btn_confirm};
    assign btn_edge = btn_now & ~btn_prev_q;
    assign {e_up, e_down, e_left, e_right, e_confirm} = btn_edge;
    assign lfsr_fb  = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

    // Free-running housekeeping: button history, LFSR and blink divider.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            btn_prev_q  <= '0;
            lfsr_q      <= 16'hACE1;
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else begin
            btn_prev_q <= btn_now;
            lfsr_q     <= {lfsr_q[14:0], lfsr_fb};
            if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
                blink_cnt_q <= '0;
                blink_q     <= ~blink_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + 1'b1;
            end
        end
    end

    // Answer generation: accept an LFSR nibble only if it is a fresh decimal digit.
    always_comb begin
        gen_used = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if ((SW'(i) < gen_idx_q) && (answer_q[i] == lfsr_q[3:0])) gen_used = 1'b1;
        gen_accept = (lfsr_q[3:0] <= 4'd9) && !gen_used;
    end

    // Strike/ball scoring of the current guess against the answer.
    always_comb begin
        strikes_c = '0;
        balls_c   = '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            for (int j = 0; j < NUM_DIGITS; j++)
                if (guess_q[i] == answer_q[j]) begin
                    if (i == j) strikes_c = strikes_c + SW'(1);
                    else        balls_c   = balls_c + SW'(1);
                end
    end

    // Digit edit and cursor move; confirm suppresses both, up beats down, right beats left.
    always_comb begin
        edit_src  = (state_q == S_INPUT_ANSWER) ? answer_q : guess_q;
        edit_res  = edit_src;
        cur_digit = edit_src[cursor_q];
        cursor_mv = cursor_q;
        if (!e_confirm) begin
            if (e_up)
                edit_res[cursor_q] = (cur_digit == 4'd9) ? 4'd0 : cur_digit + 4'd1;
            else if (e_down)
                edit_res[cursor_q] = (cur_digit == 4'd0) ? 4'd9 : cur_digit - 4'd1;
            if (e_right)
                cursor_mv = (cursor_q == CW'(NUM_DIGITS - 1)) ? '0 : cursor_q + 1'b1;
            else if (e_left)
                cursor_mv = (cursor_q == '0) ? CW'(NUM_DIGITS - 1) : cursor_q - 1'b1;
        end
    end

    // Game FSM next-state and datapath updates.
    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d    = state_q;
        answer_d   = answer_q;
        guess_d    = guess_q;
        cursor_d   = cursor_q;
        led_d      = led_q;
        attempts_d = attempts_q;
        strikes_d  = strikes_q;
        balls_d    = balls_q;
        gen_idx_d  = gen_idx_q;
        unique case (state_q)
            S_IDLE: begin
                // Only reached with active=1; active=0 is handled by the register reset path.
                state_d    = solo ? S_GEN_ANSWER : S_INPUT_ANSWER;
                answer_d   = '0;
                guess_d    = '0;
                cursor_d   = '0;
                led_d      = '0;
                attempts_d = '0;
                gen_idx_d  = '0;
            end
            S_GEN_ANSWER: if (gen_accept) begin
                answer_d[gen_idx_q[CW-1:0]] = lfsr_q[3:0];
                gen_idx_d = gen_idx_q + SW'(1);
                if (gen_idx_q == SW'(NUM_DIGITS - 1)) state_d = S_INPUT_GUESS;
            end
            S_INPUT_ANSWER: begin
                if (e_confirm) state_d = S_ANSWER_CONFIRM;
                answer_d = edit_res;
                cursor_d = cursor_mv;
            end
            S_ANSWER_CONFIRM:
                if (e_confirm) state_d = has_dup(answer_q) ? S_INPUT_ANSWER : S_INPUT_GUESS;
            S_INPUT_GUESS: begin
                guess_d  = edit_res;
                cursor_d = cursor_mv;
                if (e_confirm) begin
                    if (has_dup(guess_q)) begin
                        state_d = S_GUESS_ERR;
                    end else begin
                        strikes_d  = strikes_c;
                        balls_d    = balls_c;
                        attempts_d = attempts_q + AW'(1);
                        led_d[attempts_q[LW-1:0]] = 1'b1;
                        if (strikes_c == SW'(NUM_DIGITS))              state_d = S_GAME_WIN;
                        else if (attempts_q == AW'(MAX_ATTEMPTS - 1))  state_d = S_GAME_LOSE;
                        else                                           state_d = S_SHOW_RESULT;
                    end
                end
            end
            S_GUESS_ERR:   if (e_confirm) state_d = S_INPUT_GUESS;
            S_SHOW_RESULT: if (e_confirm) begin
                state_d  = S_INPUT_GUESS;
                cursor_d = '0;
            end
            S_GAME_WIN, S_GAME_LOSE: if (e_confirm) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Game registers; reset or active=0 returns everything to its idle values.
    always_ff @(posedge clk) begin
        // NOTE: answer/guess storage is reset explicitly because its cleared value is visible on the display.
        if (reset || !active) begin
            state_q    <= S_IDLE;
            answer_q   <= '0;
            guess_q    <= '0;
            cursor_q   <= '0;
            led_q      <= '0;
            attempts_q <= '0;
            strikes_q  <= '0;
            balls_q    <= '0;
            gen_idx_q  <= '0;
        end else begin
            state_q    <= state_d;
            answer_q   <= answer_d;
            guess_q    <= guess_d;
            cursor_q   <= cursor_d;
            led_q      <= led_d;
            attempts_q <= attempts_d;
            strikes_q  <= strikes_d;
            balls_q    <= balls_d;
            gen_idx_q  <= gen_idx_d;
        end
    end

    // Display encoder: one character code per slot, slot 0 rightmost.
    always_comb begin
        seg_c = '0;
        unique case (state_q)
            S_IDLE: seg_c = '0;
            S_GEN_ANSWER:
                for (int i = 0; i < NUM_DIGITS; i++) seg_c[i] = CH_DASH;
            S_INPUT_ANSWER, S_INPUT_GUESS:
                for (int i = 0; i < NUM_DIGITS; i++)
                    seg_c[i] = (blink_q && (cursor_q == CW'(i))) ? CH_BLANK : {1'b0, edit_src[i]};
            S_ANSWER_CONFIRM:
                seg_c = has_dup(answer_q) ? text4(CH_DASH, CH_E, CH_R, CH_R)
                                          : text4(CH_G, CH_O, CH_G, CH_O);
            S_GUESS_ERR:   seg_c = text4(CH_DASH, CH_E, CH_R, CH_R);
            S_SHOW_RESULT: seg_c = text4(5'(strikes_q), CH_S, 5'(balls_q), CH_B);
            S_GAME_WIN:    seg_c = text4(CH_G, CH_O, CH_O, CH_D);
            S_GAME_LOSE:   seg_c = text4(CH_L, CH_O, CH_S, CH_E);
            default:       seg_c = '0;
        endcase
    end

    assign seg_data = seg_c;
    assign led      = led_q;
    assign win      = (state_q == S_GAME_WIN);
    assign lose     = (state_q == S_GAME_LOSE);

endmodule

// File: tb/tb_baseball_game_param.sv
// Self-checking bench for baseball_game_param (4 digits, 4 attempts, blink every 4 cycles).
module tb_baseball_game_param;

    localparam int ND = 4;
    localparam int MA = 4;
    localparam int BD = 4;
    localparam int LFSR_LEN = 20000;

    localparam logic [4:0] UP = 5'b10000;
    localparam logic [4:0] DN = 5'b01000;
    localparam logic [4:0] LT = 5'b00100;
    localparam logic [4:0] RT = 5'b00010;
    localparam logic [4:0] CF = 5'b00001;

    typedef struct {
        int          guess;
        logic [19:0] seg;
        logic [3:0]  led;
        logic        win;
        logic        lose;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1, active = 1'b0, solo = 1'b0;
    logic btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_confirm = 1'b0;
    logic [MA-1:0]   led;
    logic [5*ND-1:0] seg_data;
    logic            win, lose;

    int n_cmp = 0;
    int n_bad = 0;
    int n_cyc = 0;
    int reg_m[ND];
    logic [15:0] lfsr_tab[LFSR_LEN];

    baseball_game_param #(.NUM_DIGITS(ND), .MAX_ATTEMPTS(MA), .BLINK_DIV(BD)) dut (
        .clk(clk), .reset(reset), .active(active), .solo(solo),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
        .btn_right(btn_right), .btn_confirm(btn_confirm),
        .led(led), .seg_data(seg_data), .win(win), .lose(lose)
    );

    always #5 clk = ~clk;

    // Edges since the last reset edge: drives the blink and LFSR reference.
    always @(posedge clk) begin
        if (reset) n_cyc <= 0;
        else       n_cyc <= n_cyc + 1;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, n_cyc=%0d", n_cyc);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic int dig(input int v, input int k);
        for (int i = 0; i < k; i++) v = v / 10;
        return v % 10;
    endfunction

    function automatic logic [19:0] txt(input int a, input int b, input int c, input int d);
        return {5'(a), 5'(b), 5'(c), 5'(d)};
    endfunction

    function automatic logic dup_m(input int v);
        for (int i = 0; i < ND; i++)
            for (int j = i + 1; j < ND; j++)
                if (dig(v, i) == dig(v, j)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic score(input int a, input int g, output int s, output int b);
        s = 0;
        b = 0;
        for (int i = 0; i < ND; i++)
            for (int j = 0; j < ND; j++)
                if (dig(g, i) == dig(a, j)) begin
                    if (i == j) s++;
                    else        b++;
                end
    endtask

    // Edited register as shown: cursor slot blank during the blink-on half period.
    function automatic logic [19:0] exp_input(input int c);
        logic [19:0] s;
        logic bl;
        bl = ((n_cyc / BD) % 2) == 1;
        for (int i = 0; i < ND; i++)
            s[i*5 +: 5] = (bl && i == c) ? 5'd31 : 5'(reg_m[i]);
        return s;
    endfunction

    task automatic press(input logic [4:0] m);
        {btn_up, btn_down, btn_left, btn_right, btn_confirm} = m;
        @(negedge clk);
        {btn_up, btn_down, btn_left, btn_right, btn_confirm} = 5'b0;
        @(negedge clk);
    endtask

    // Dial every slot to the target value with up presses, cursor ends back at 0.
    task automatic set_value(input int v);
        for (int k = 0; k < ND; k++) begin
            int ups;
            ups = (dig(v, k) - reg_m[k] + 10) % 10;
            repeat (ups) press(UP);
            reg_m[k] = dig(v, k);
            press(RT);
        end
    endtask

    task automatic clear_model();
        for (int k = 0; k < ND; k++) reg_m[k] = 0;
    endtask

    task automatic start_player();
        active = 1'b0;
        solo   = 1'b0;
        @(negedge clk);
        check("idle_seg", seg_data, 0);
        active = 1'b1;
        @(negedge clk);
        clear_model();
    endtask

    function automatic int rand_distinct();
        int pool[10];
        int v, t, r;
        for (int i = 0; i < 10; i++) pool[i] = i;
        for (int i = 0; i < ND; i++) begin
            r = $urandom_range(i, 9);
            t = pool[i]; pool[i] = pool[r]; pool[r] = t;
        end
        v = 0;
        for (int i = ND - 1; i >= 0; i--) v = v * 10 + pool[i];
        return v;
    endfunction

    function automatic int rand_any();
        int v;
        v = 0;
        for (int i = 0; i < ND; i++) v = v * 10 + int'($urandom_range(0, 9));
        return v;
    endfunction

    initial begin
        vec_t tbl[5];
        logic [15:0] t;
        int ans, g, s, b, att, led_m, m_idx, v, sv;
        int m_ans[ND];
        logic done, used;

        tbl[0] = '{1243, txt(2, 5, 2, 18),    4'b0001, 1'b0, 1'b0};
        tbl[1] = '{5678, txt(0, 5, 0, 18),    4'b0011, 1'b0, 1'b0};
        tbl[2] = '{5567, txt(10, 11, 12, 12), 4'b0011, 1'b0, 1'b0};
        tbl[3] = '{4321, txt(0, 5, 4, 18),    4'b0111, 1'b0, 1'b0};
        tbl[4] = '{2135, txt(1, 17, 5, 11),   4'b1111, 1'b0, 1'b1};

        t = 16'hACE1;
        for (int k = 0; k < LFSR_LEN; k++) begin
            lfsr_tab[k] = t;
            t = {t[14:0], t[15] ^ t[13] ^ t[12] ^ t[10]};
        end

        // Reset state.
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_seg", seg_data, 0);
        check("rst_led", led, 0);
        check("rst_win", win, 0);
        check("rst_lose", lose, 0);

        // Player mode: duplicate answer rejected, then a valid one.
        reset  = 1'b0;
        active = 1'b1;
        @(negedge clk);
        clear_model();
        check("ans_entry", seg_data, exp_input(0));
        set_value(1123);
        press(CF);
        check("ans_dup_err", seg_data, txt(10, 11, 12, 12));
        press(CF);
        check("ans_retained", seg_data, exp_input(0));
        set_value(1234);
        press(CF);
        check("ans_gogo", seg_data, txt(9, 17, 9, 17));
        press(CF);
        clear_model();
        check("guess_entry", seg_data, exp_input(0));

        // Scripted guesses against answer 1234.
        for (int r = 0; r < 5; r++) begin
            set_value(tbl[r].guess);
            press(CF);
            check($sformatf("row%0d_seg", r), seg_data, tbl[r].seg);
            check($sformatf("row%0d_led", r), led, tbl[r].led);
            check($sformatf("row%0d_win", r), win, tbl[r].win);
            check($sformatf("row%0d_lose", r), lose, tbl[r].lose);
            if (!tbl[r].lose) begin
                press(CF);
                check($sformatf("row%0d_back", r), seg_data, exp_input(0));
            end
        end

        // Confirm in GAME_LOSE: one cycle of IDLE, then straight back to entry.
        btn_confirm = 1'b1;
        @(negedge clk);
        check("lose_idle_seg", seg_data, 0);
        check("lose_idle_flag", lose, 0);
        check("lose_idle_led", led, 4'b1111);
        btn_confirm = 1'b0;
        @(negedge clk);
        clear_model();
        check("reentry_led", led, 0);
        check("reentry_seg", seg_data, exp_input(0));

        // Edit corner cases.
        press(DN);
        reg_m[0] = 9;
        check("down_wrap", seg_data, exp_input(0));
        press(UP | DN | RT);
        reg_m[0] = 0;
        check("updown_right", seg_data, exp_input(1));
        press(LT);
        press(LT);
        check("left_wrap", seg_data, exp_input(3));
        press(RT);
        press(UP | CF);
        check("confirm_blocks_edit", seg_data, txt(10, 11, 12, 12));
        press(CF);
        check("confirm_blocks_back", seg_data, exp_input(0));

        // Reset arriving during SHOW_RESULT.
        set_value(1234);
        press(CF);
        press(CF);
        clear_model();
        set_value(1243);
        press(CF);
        check("pre_rst_seg", seg_data, txt(2, 5, 2, 18));
        reset = 1'b1;
        @(negedge clk);
        check("midrst_seg", seg_data, 0);
        check("midrst_led", led, 0);
        check("midrst_win", win, 0);
        check("midrst_lose", lose, 0);
        reset = 1'b0;
        @(negedge clk);
        clear_model();
        check("midrst_reentry", seg_data, exp_input(0));
        press(DN);
        reg_m[0] = 9;
        repeat (3) @(negedge clk);
        check("midrst_blink", seg_data, exp_input(0));

        // Random player games checked against the scoring model.
        for (int gm = 0; gm < 6; gm++) begin
            start_player();
            ans = rand_distinct();
            set_value(ans);
            press(CF);
            check("rg_gogo", seg_data, txt(9, 17, 9, 17));
            press(CF);
            clear_model();
            check("rg_entry", seg_data, exp_input(0));
            att   = 0;
            led_m = 0;
            done  = 1'b0;
            for (int tr = 0; tr < 8 && !done; tr++) begin
                g = ($urandom_range(0, 3) == 0) ? ans : rand_any();
                set_value(g);
                press(CF);
                if (dup_m(g)) begin
                    check("rg_dup_seg", seg_data, txt(10, 11, 12, 12));
                    check("rg_dup_led", led, led_m);
                    press(CF);
                    check("rg_dup_back", seg_data, exp_input(0));
                end else begin
                    score(ans, g, s, b);
                    led_m = led_m | (1 << att);
                    att++;
                    check("rg_led", led, led_m);
                    if (s == ND) begin
                        check("rg_win", win, 1);
                        check("rg_win_seg", seg_data, txt(9, 17, 17, 19));
                        done = 1'b1;
                    end else if (att == MA) begin
                        check("rg_lose", lose, 1);
                        check("rg_lose_seg", seg_data, txt(1, 17, 5, 11));
                        done = 1'b1;
                    end else begin
                        check("rg_result", seg_data, txt(s, 5, b, 18));
                        check("rg_nowin", win, 0);
                        press(CF);
                        check("rg_back", seg_data, exp_input(0));
                    end
                end
            end
        end

        // Solo mode: rebuild the generated answer from the LFSR sequence, then guess it.
        active = 1'b0;
        solo   = 1'b1;
        @(negedge clk);
        active = 1'b1;
        @(negedge clk);
        m_idx = 0;
        done  = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            if (seg_data == {ND{5'd10}}) begin
                v = (n_cyc < LFSR_LEN) ? int'(lfsr_tab[n_cyc][3:0]) : 15;
                used = 1'b0;
                for (int j = 0; j < m_idx; j++)
                    if (m_ans[j] == v) used = 1'b1;
                if (v <= 9 && !used && m_idx < ND) begin
                    m_ans[m_idx] = v;
                    m_idx++;
                end
                @(negedge clk);
            end else begin
                done = 1'b1;
            end
        end
        check("gen_exit", done, 1);
        check("gen_digits", m_idx, ND);
        clear_model();
        check("gen_guess_entry", seg_data, exp_input(0));
        sv = 0;
        for (int k = ND - 1; k >= 0; k--) sv = sv * 10 + m_ans[k];
        set_value(sv);
        press(CF);
        check("solo_win", win, 1);
        check("solo_win_seg", seg_data, txt(9, 17, 17, 19));
        check("solo_led", led, 4'b0001);

        // Reset together with confirm in GAME_WIN.
        btn_confirm = 1'b1;
        reset       = 1'b1;
        @(negedge clk);
        check("rstcf_seg", seg_data, 0);
        check("rstcf_led", led, 0);
        check("rstcf_win", win, 0);
        reset       = 1'b0;
        btn_confirm = 1'b0;
        active      = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
